// File: rtl/sram_bist_ctrl_if.sv
// rtl/sram_bist_ctrl_if.sv - functional-side and SRAM-side port bundle for the March C- BIST mux.
// master: the BIST controller (consumes f_* and sram_q, drives sram_*); slave: the surrounding fabric.
interface sram_bist_if #(
  parameter int ADDR_DEPTH = 12,
  parameter int DATA_WIDTH = 8
) ();
  logic [3:0]              f_csn;
  logic                    f_w_en;
  logic                    f_r_en;
  logic [ADDR_DEPTH-1:0]   f_addr;
  logic [4*DATA_WIDTH-1:0] f_wdata;

  logic [3:0]              sram_csn;
  logic                    sram_w_en;
  logic                    sram_r_en;
  logic [ADDR_DEPTH-1:0]   sram_addr;
  logic [4*DATA_WIDTH-1:0] sram_wdata;
  logic [4*DATA_WIDTH-1:0] sram_q;

  modport master (
    input  f_csn, f_w_en, f_r_en, f_addr, f_wdata, sram_q,
    output sram_csn, sram_w_en, sram_r_en, sram_addr, sram_wdata
  );

  modport slave (
    output f_csn, f_w_en, f_r_en, f_addr, f_wdata, sram_q,
    input  sram_csn, sram_w_en, sram_r_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST controller owning the 4-bank SRAM port through a 2:1 mux.
// Optional first-failure capture (fail_addr/fail_bank/fail_elem) is built when BIST_FAIL_LOG_EN is defined.
module sram_bist_ctrl #(
  parameter int ADDR_DEPTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_DEPTH-1:0] fail_addr,
  output logic [3:0]            fail_bank,
  output logic [2:0]            fail_elem,
  sram_bist_if.master           bus
);

  localparam int WORD_W = 4 * DATA_WIDTH;
  localparam logic [ADDR_DEPTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_DEPTH-1:0] ADDR_ONE = {{(ADDR_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, M5_CHK, DONE
  } state_t;

  state_t                state, state_d;
  logic [ADDR_DEPTH-1:0] addr, addr_d;
  logic                  phase, phase_d;
  logic                  chk_vld;

  logic                  m_w_en, m_r_en, m_wbg, cmp_en;
  logic                  el_up, el_rd_bg, el_wr_bg, el_last;
  logic [ADDR_DEPTH-1:0] el_nstart, addr_step;
  state_t                el_next;

  logic                  entering_m0;
  logic                  exp_bg, cmp_any;
  logic [3:0]            mism;

  // Direction, backgrounds and successor of each read-modify-write element (M1..M4).
  always_comb begin
    el_up     = 1'b1;
    el_rd_bg  = 1'b0;
    el_wr_bg  = 1'b0;
    el_nstart = '0;
    el_next   = IDLE;
    case (state)
      M1: begin el_wr_bg = 1'b1; el_next = M2; end
      M2: begin el_rd_bg = 1'b1; el_next = M3; el_nstart = ADDR_MAX; end
      M3: begin el_up = 1'b0; el_wr_bg = 1'b1; el_next = M4; el_nstart = ADDR_MAX; end
      M4: begin el_up = 1'b0; el_rd_bg = 1'b1; el_next = M5; end
      default: ;
    endcase
  end

  assign el_last   = el_up ? (addr == ADDR_MAX) : (addr == '0);
  assign addr_step = el_up ? (addr + ADDR_ONE) : (addr - ADDR_ONE);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      addr    <= '0;
      phase   <= 1'b0;
      chk_vld <= 1'b0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      phase   <= phase_d;
      chk_vld <= (state == M5);
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    phase_d = phase;
    m_w_en  = 1'b0;
    m_r_en  = 1'b0;
    m_wbg   = 1'b0;
    cmp_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bist_start) begin
          state_d = M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      M0: begin
        m_w_en = 1'b1;
        if (addr == ADDR_MAX) begin
          state_d = M1;
          addr_d  = '0;
        end else begin
          addr_d = addr + ADDR_ONE;
        end
      end
      M1, M2, M3, M4: begin
        if (!phase) begin
          m_r_en  = 1'b1;
          phase_d = 1'b1;
        end else begin
          // Read data from the previous cycle is checked while the new value is written.
          m_w_en  = 1'b1;
          m_wbg   = el_wr_bg;
          cmp_en  = 1'b1;
          phase_d = 1'b0;
          if (el_last) begin
            state_d = el_next;
            addr_d  = el_nstart;
          end else begin
            addr_d = addr_step;
          end
        end
      end
      M5: begin
        m_r_en = 1'b1;
        if (addr == ADDR_MAX) begin
          state_d = M5_CHK;
          addr_d  = '0;
        end else begin
          addr_d = addr + ADDR_ONE;
        end
      end
      M5_CHK: state_d = DONE;
      DONE: begin
        if (!bist_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bist_busy = (state != IDLE) && (state != DONE);
  assign bist_done = (state == DONE);

  assign bus.sram_csn   = bist_busy ? 4'b0000 : bus.f_csn;
  assign bus.sram_w_en  = bist_busy ? m_w_en : bus.f_w_en;
  assign bus.sram_r_en  = bist_busy ? m_r_en : bus.f_r_en;
  assign bus.sram_addr  = bist_busy ? addr : bus.f_addr;
  assign bus.sram_wdata = bist_busy ? {WORD_W{m_wbg}} : bus.f_wdata;

  // M5 compares are delayed by one cycle and always expect the all-zero background.
  assign entering_m0 = (state == IDLE) && bist_start;
  assign exp_bg      = cmp_en & el_rd_bg;
  assign cmp_any     = cmp_en | chk_vld;

  always_comb begin
    mism = '0;
    for (int b = 0; b < 4; b++) begin
      mism[b] = cmp_any && (|(bus.sram_q[b*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{exp_bg}}));
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bist_fail <= 1'b0;
    end else if (entering_m0) begin
      bist_fail <= 1'b0;
    end else if (|mism) begin
      bist_fail <= 1'b1;
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_DEPTH-1:0] chk_addr;
  logic [ADDR_DEPTH-1:0] cmp_addr;
  logic [2:0]            cmp_elem;
  logic [3:0]            st_raw;

  // M1..M4 encode as 2..5, so the element index is the state code minus one.
  assign st_raw   = state;
  assign cmp_addr = cmp_en ? addr : chk_addr;
  assign cmp_elem = cmp_en ? 3'(st_raw - 4'd1) : 3'd5;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      chk_addr  <= '0;
      fail_addr <= '0;
      fail_bank <= '0;
      fail_elem <= '0;
    end else begin
      chk_addr <= addr;
      if (entering_m0) begin
        fail_addr <= '0;
        fail_bank <= '0;
        fail_elem <= '0;
      end else if ((|mism) && !bist_fail) begin
        fail_addr <= cmp_addr;
        fail_bank <= mism;
        fail_elem <= cmp_elem;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_bank = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - directed bench for sram_bist_ctrl with a behavioural 4-bank SRAM model.
module tb_sram_bist_ctrl;
  localparam int AD = 12;
  localparam int N  = 4096;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          bist_start = 1'b0;
  logic          bist_busy, bist_done, bist_fail;
  logic [AD-1:0] fail_addr;
  logic [3:0]    fail_bank;
  logic [2:0]    fail_elem;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  sram_bist_if #(.ADDR_DEPTH(AD), .DATA_WIDTH(8)) bus ();

  sram_bist_ctrl #(.ADDR_DEPTH(AD), .DATA_WIDTH(8)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .bist_start (bist_start),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done),
    .bist_fail  (bist_fail),
    .fail_addr  (fail_addr),
    .fail_bank  (fail_bank),
    .fail_elem  (fail_elem),
    .bus        (bus.master)
  );

  always #5 hclk = ~hclk;

  logic [31:0] mem [N];
  logic        stuck_en = 1'b0;

  // Bank 2, address 0x00A, bit 3 reads as 1 when the fault is enabled.
  always @(posedge hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (!bus.sram_csn[b]) begin
        if (bus.sram_w_en) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
        if (bus.sram_r_en)
          bus.sram_q[b*8 +: 8] <= mem[bus.sram_addr][b*8 +: 8] |
                                  ((stuck_en && bus.sram_addr == 12'h00A && b == 2) ? 8'h08 : 8'h00);
      end
    end
  end

  typedef struct {
    logic [3:0]  csn;
    logic        w_en;
    logic        r_en;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_q;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  task automatic f_idle();
    bus.f_csn   = 4'hF;
    bus.f_w_en  = 1'b0;
    bus.f_r_en  = 1'b0;
    bus.f_addr  = '0;
    bus.f_wdata = '0;
  endtask

  task automatic chk_log(input logic [11:0] ea, input logic [3:0] eb, input logic [2:0] ee);
`ifdef BIST_FAIL_LOG_EN
    chk("fail_addr", fail_addr, ea);
    chk("fail_bank", fail_bank, eb);
    chk("fail_elem", fail_elem, ee);
`else
    chk("fail_addr_tied", fail_addr, 12'h0);
    chk("fail_bank_tied", fail_bank, 4'h0);
    chk("fail_elem_tied", fail_elem, 3'h0);
    if (ea == 12'hFFF && eb == 4'hF && ee == 3'h7) $display("unreachable log pattern");
`endif
  endtask

  initial begin
    int nonzero;

    vecs[0] = '{4'h0, 1'b1, 1'b0, 12'h010, 32'hA5A5_5A5A, 1'b0, 32'h0};
    vecs[1] = '{4'h0, 1'b0, 1'b1, 12'h010, 32'h0,         1'b1, 32'hA5A5_5A5A};
    vecs[2] = '{4'hB, 1'b1, 1'b0, 12'h010, 32'h1122_3344, 1'b0, 32'h0};
    vecs[3] = '{4'h0, 1'b0, 1'b1, 12'h010, 32'h0,         1'b1, 32'hA522_5A5A};
    vecs[4] = '{4'h6, 1'b1, 1'b0, 12'h010, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[5] = '{4'h0, 1'b0, 1'b1, 12'h010, 32'h0,         1'b1, 32'hFF22_5AFF};

    f_idle();
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_busy", bist_busy, 1'b0);
    chk("rst_done", bist_done, 1'b0);
    chk("rst_fail", bist_fail, 1'b0);
    chk_log(12'h0, 4'h0, 3'h0);
    chk("rst_csn_mirror", bus.sram_csn, 4'hF);
    @(posedge hclk);
    #1 hresetn = 1'b1;

    // Functional pass-through vectors
    for (int i = 0; i < 6; i++) begin
      bus.f_csn   = vecs[i].csn;
      bus.f_w_en  = vecs[i].w_en;
      bus.f_r_en  = vecs[i].r_en;
      bus.f_addr  = vecs[i].addr;
      bus.f_wdata = vecs[i].wdata;
      @(negedge hclk);
      chk("mux_csn", bus.sram_csn, vecs[i].csn);
      chk("mux_w_en", bus.sram_w_en, vecs[i].w_en);
      chk("mux_r_en", bus.sram_r_en, vecs[i].r_en);
      chk("mux_addr", bus.sram_addr, vecs[i].addr);
      chk("mux_wdata", bus.sram_wdata, vecs[i].wdata);
      chk("func_busy", bist_busy, 1'b0);
      @(posedge hclk);
      #1;
      if (vecs[i].chk_q) chk("func_rdata", bus.sram_q, vecs[i].exp_q);
    end
    f_idle();

    // Run A: stuck-at fault, start held high through DONE
    stuck_en = 1'b1;
    bist_start = 1'b1;
    @(posedge hclk);
    #1;
    cyc = 1;
    chk("a_busy_c1", bist_busy, 1'b1);
    chk("a_csn_c1", bus.sram_csn, 4'h0);
    chk("a_m0_w_en", bus.sram_w_en, 1'b1);
    chk("a_m0_r_en", bus.sram_r_en, 1'b0);
    chk("a_m0_addr", bus.sram_addr, 12'h000);
    chk("a_m0_wdata", bus.sram_wdata, 32'h0);
    while (cyc < N + 1) step();
    chk("a_m1_r_en", bus.sram_r_en, 1'b1);
    chk("a_m1_w_en", bus.sram_w_en, 1'b0);
    chk("a_m1_addr", bus.sram_addr, 12'h000);
    while (cyc < 4118) step();
    chk("a_fail_before", bist_fail, 1'b0);
    step();
    chk("a_fail_after", bist_fail, 1'b1);
    chk_log(12'h00A, 4'b0100, 3'd1);

    while (cyc < 4161) step();
    bus.f_csn   = 4'h0;
    bus.f_w_en  = 1'b1;
    bus.f_addr  = 12'h020;
    bus.f_wdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_w_en", bus.sram_w_en, 1'b0);
    chk("drop_r_en", bus.sram_r_en, 1'b1);
    chk("drop_addr", bus.sram_addr, 12'h020);
    chk("drop_wdata", bus.sram_wdata, 32'h0);
    step();
    f_idle();
    chk("m1_wr_w_en", bus.sram_w_en, 1'b1);
    chk("m1_wr_wdata", bus.sram_wdata, 32'hFFFF_FFFF);

    while (cyc < 10 * N + 1) step();
    chk("a_done_pre", bist_done, 1'b0);
    chk("a_busy_chk", bist_busy, 1'b1);
    chk("a_chk_enables", {bus.sram_w_en, bus.sram_r_en}, 2'b00);
    step();
    chk("a_done_40962", bist_done, 1'b1);
    chk("a_busy_done", bist_busy, 1'b0);
    chk("a_fail_done", bist_fail, 1'b1);
    chk_log(12'h00A, 4'b0100, 3'd1);
    repeat (5) step();
    chk("a_hold_done", bist_done, 1'b1);
    chk("a_hold_busy", bist_busy, 1'b0);
    nonzero = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== 32'h0) nonzero++;
    chk("a_mem_nonzero", nonzero, 0);
    chk("a_mem_020", mem[12'h020], 32'h0);
    bist_start = 1'b0;
    step();
    chk("a_idle_done", bist_done, 1'b0);
    chk("a_idle_fail_sticky", bist_fail, 1'b1);

    // Run B: fault removed, restart clears status, reset mid-run
    stuck_en = 1'b0;
    bist_start = 1'b1;
    @(posedge hclk);
    #1;
    cyc = 1;
    bist_start = 1'b0;
    chk("b_busy_c1", bist_busy, 1'b1);
    chk("b_fail_cleared", bist_fail, 1'b0);
    chk_log(12'h0, 4'h0, 3'h0);
    while (cyc < 20000) step();
    chk("b_fail_20000", bist_fail, 1'b0);
    chk("b_busy_20000", bist_busy, 1'b1);
    #2;
    bus.f_csn   = 4'b1010;
    bus.f_r_en  = 1'b1;
    bus.f_addr  = 12'h123;
    bus.f_wdata = 32'h0BAD_F00D;
    hresetn = 1'b0;
    #1;
    chk("r_busy", bist_busy, 1'b0);
    chk("r_done", bist_done, 1'b0);
    chk("r_fail", bist_fail, 1'b0);
    chk_log(12'h0, 4'h0, 3'h0);
    chk("r_csn", bus.sram_csn, 4'b1010);
    chk("r_en_pair", {bus.sram_w_en, bus.sram_r_en}, 2'b01);
    chk("r_addr", bus.sram_addr, 12'h123);
    chk("r_wdata", bus.sram_wdata, 32'h0BAD_F00D);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    step();
    chk("post_busy", bist_busy, 1'b0);
    chk("post_addr", bus.sram_addr, 12'h123);
    chk("post_csn", bus.sram_csn, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- March C- built-in self-test controller for the four-bank (4 x 8-bit x 4096) byte-lane SRAM array behind the AHB slave interface.
- Sits between the AHB slave interface's SRAM-side outputs and the four sram instances, and owns the SRAM port through a 2:1 mux (functional vs BIST).
- On request, takes exclusive ownership of the SRAM, runs the full march on all banks in parallel, then returns pass/fail status and hands the SRAM back.

Parameters:
- ADDR_DEPTH, 12, SRAM address width; march covers 0 .. 2^ADDR_DEPTH-1.
- DATA_WIDTH, 8, width of one bank; 4 banks form a 32-bit word.

Ports:
- hclk  input  1  clock
- hresetn  input  1  asynchronous active-low reset
- bist_start  input  1  level request; starts a run when sampled high in IDLE
- bist_busy  output  1  high while BIST owns the SRAM; functional accesses are dropped
- bist_done  output  1  high while in DONE
- bist_fail  output  1  sticky mismatch flag for the last run
- fail_addr  output  ADDR_DEPTH  first failing address (optional feature)
- fail_bank  output  4  bank mask of the first failing compare (optional feature)
- fail_elem  output  3  march element index (0-5) of the first failure (optional feature)
- f_csn  input  4  functional bank chip selects, active low
- f_w_en  input  1  functional write enable
- f_r_en  input  1  functional read enable
- f_addr  input  ADDR_DEPTH  functional address
- f_wdata  input  32  functional write data
- sram_csn  output  4  to the sram cs_n pins
- sram_w_en  output  1  to the sram w_en pins
- sram_r_en  output  1  to the sram r_en pins
- sram_addr  output  ADDR_DEPTH  to the sram addr pins
- sram_wdata  output  32  to the sram din pins; byte n goes to bank n
- sram_q  input  32  {q3,q2,q1,q0}; valid the cycle after a read-enable cycle

Behaviour:
- Interface: one clock (hclk); reset is asynchronous and active-low (hresetn).
- Reset values: state IDLE; bist_busy, bist_done, bist_fail = 0; fail_addr, fail_bank, fail_elem = 0; address counter = 0.
- Mux: when bist_busy = 0, the sram_* outputs equal the f_* inputs (combinational pass-through). When bist_busy = 1:
  - sram_csn = 4'b0000;
  - sram_w_en, sram_r_en, sram_addr, sram_wdata are driven by the FSM;
  - unused enables are held at 0.
- States: IDLE, M0, M1, M2, M3, M4, M5, M5_CHK, DONE. bist_busy = 1 in M0..M5_CHK.
- IDLE -> M0 when bist_start = 1. Entering M0 clears bist_fail and the fail log.
- Elements (0 = 32'h0000_0000, 1 = 32'hFFFF_FFFF):
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Up elements start at address 0; down elements start at 2^ADDR_DEPTH-1.
- M0: one write per cycle, 2^ADDR_DEPTH cycles.
- M1..M4: two cycles per address.
  - Phase RD: r_en = 1.
  - Phase WR: w_en = 1, and sram_q is compared with the expected background in the same cycle.
  - The address advances after WR.
- M5: one read per cycle. The compare for address a occurs in the following cycle, using a registered valid flag and expected data.
- M5_CHK: one cycle for the final compare only; no enables asserted.
- Element transition occurs after the last address of the element, with no idle cycle. The counter wraps to the next element's start address.
- Mismatch: any bit difference sets bist_fail (sticky until the next M0 entry). Per-bank mismatch = OR-reduce of that byte's XOR.
- M5_CHK -> DONE. DONE -> IDLE when bist_start = 0. bist_start held high in DONE does not restart a run.
- bist_start is ignored while busy.
- Timing: start sampled at cycle 0 gives M0 at cycles 1..N (N = 2^ADDR_DEPTH), M5_CHK at cycle 10N+1, and bist_done = 1 from cycle 10N+2. For defaults, bist_done rises at cycle 40962.
- Functional accesses presented while busy are discarded (not queued). Upstream stalls using bist_busy.
- Reset mid-run: returns immediately to IDLE with all outputs at reset values. SRAM contents are undefined afterwards.

Optional Feature:
- Macro BIST_FAIL_LOG_EN.
- Defined: on the first mismatch of a run, capture fail_addr (address of the compared read), fail_bank (per-bank mismatch mask) and fail_elem. Later mismatches do not overwrite the capture. Values hold until the next M0 entry.
- Undefined: no capture registers are built; fail_addr, fail_bank and fail_elem are tied to 0. bist_fail behaviour is unchanged.

Test Plan:
- Reset, then functional write 32'hA5A5_5A5A at addr 12'h010 via f_* and read back -> sram_* mirror the f_* inputs; read returns 32'hA5A5_5A5A; bist_busy = 0.
- bist_start pulse high with a fault-free model -> bist_busy = 1 from cycle 1; bist_done = 1 at cycle 40962; bist_fail = 0; final memory is all 0.
- Model bank 2 addr 12'h00A bit 3 stuck-at-1 -> bist_fail = 1; with BIST_FAIL_LOG_EN: fail_addr = 12'h00A, fail_bank = 4'b0100, fail_elem = 1.
- Assert hresetn low at cycle 20000 of a run -> all outputs 0 asynchronously; state IDLE; sram_* follow f_* after release.
- Hold bist_start high through DONE -> no second run; drop bist_start -> IDLE; reassert -> new run, bist_fail cleared at M0 entry.
- Drive f_w_en = 1 while busy -> sram_w_en follows the FSM only; that SRAM location keeps its march value.
